// File: rtl/data_sort_pkg.sv
// Shared types for the streaming sorter: FSM state encoding used by block and bench.
package data_sort_pkg;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;
endpackage

// File: rtl/data_sort_cell.sv
// One slot of the insertion array: holds s[i], flags whether x lands at or before it,
// and picks keep / x / shifted-in neighbour.
module data_sort_cell #(
  parameter int W     = 8,
  parameter bit FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         desc,
  input  logic         active,
  input  logic [W-1:0] x,
  input  logic [W-1:0] prev_s,
  input  logic         prev_ins,
  output logic [W-1:0] s,
  output logic [W-1:0] nxt,
  output logic         ins
);
  // strict compare keeps equal values in arrival order
  always_comb begin
    ins = !active || (desc ? (s < x) : (s > x));
    nxt = s;
    if (ins) nxt = (FIRST || !prev_ins) ? x : prev_s;
  end

  always_ff @(posedge clk) begin
    if (rst)     s <= '0;
    else if (en) s <= nxt;
  end
endmodule

// File: rtl/data_sort_stream.sv
// Streaming insertion sorter: fills a sorted register array one sample per accept,
// then drains it serially while presenting min/median/max of the frame.
module data_sort_stream
  import data_sort_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_last_i,
  input  logic          desc_i,
  output logic [W-1:0]  out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic [W-1:0]  min_o,
  output logic [W-1:0]  med_o,
  output logic [W-1:0]  max_o,
  output logic          stat_valid_o,
  output logic [CW-1:0] len_o
);
  localparam int IW = $clog2(N);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, len_q;
  logic [IW-1:0]       rd_q, hi, half, mid;
  logic                mode_q, desc_cur, acc, frame_end, out_xfer;
  logic [N-1:0][W-1:0] s, nxt;
  logic [N-1:0]        ins;
  logic [W-1:0]        min_q, med_q, max_q;
  logic                stat_q;

  assign in_ready_o  = (state_q == FILL);
  assign acc         = in_valid_i && in_ready_o;
  assign desc_cur    = (cnt_q == '0) ? desc_i : mode_q;
  assign frame_end   = acc && (in_last_i || cnt_q == CW'(N - 1));
  assign out_valid_o = (state_q == DRAIN);
  assign out_last_o  = out_valid_o && (CW'(rd_q) == len_q - 1'b1);
  assign out_data_o  = out_valid_o ? s[rd_q] : '0;
  assign out_xfer    = out_valid_o && out_ready_i;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic [W-1:0] ps;
    logic         pi;
    if (i == 0) begin : g_first
      assign ps = '0;
      assign pi = 1'b0;
    end else begin : g_rest
      assign ps = s[i-1];
      assign pi = ins[i-1];
    end
    data_sort_cell #(.W(W), .FIRST(i == 0)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (acc),
      .desc     (desc_cur),
      .active   (cnt_q > CW'(i)),
      .x        (in_data_i),
      .prev_s   (ps),
      .prev_ins (pi),
      .s        (s[i]),
      .nxt      (nxt[i]),
      .ins      (ins[i])
    );
  end

  // Stats come from the post-insert array so they are ready on the first DRAIN cycle.
  // hi = len-1; the lower median sits at ascending index hi/2, mirrored in desc mode.
  assign hi   = cnt_q[IW-1:0];
  assign half = hi >> 1;
  assign mid  = desc_cur ? hi - half : half;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (frame_end) state_d = DRAIN;
      DRAIN:   if (out_xfer && out_last_o) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      min_q   <= '0;
      med_q   <= '0;
      max_q   <= '0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= frame_end;
      if (acc) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '0) mode_q <= desc_i;
      end
      if (frame_end) begin
        len_q <= cnt_q + 1'b1;
        min_q <= desc_cur ? nxt[hi] : nxt[0];
        max_q <= desc_cur ? nxt[0]  : nxt[hi];
        med_q <= nxt[mid];
      end
      if (out_xfer) begin
        if (out_last_o) begin
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          rd_q  <= rd_q + 1'b1;
        end
      end
    end
  end

  assign min_o        = min_q;
  assign med_o        = med_q;
  assign max_o        = max_q;
  assign stat_valid_o = stat_q;
  assign len_o        = len_q;
endmodule
